// File: rtl/onehot_mux_pipe_if.sv
// Stream-side bundle for onehot_mux_pipe: input beat, output beat and error status.
// The slave modport is the mux itself; master is whoever drives beats and drains output.
interface onehot_mux_pipe_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int ERRCNT_W = 8
) ();
  localparam int CW = $clog2(CHANNELS);

  logic                      in_valid;
  logic                      in_ready;
  logic [CHANNELS-1:0]       sel;
  logic [CHANNELS*WIDTH-1:0] data;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_data;
  logic [CW-1:0]             out_chan;
  logic                      sel_err;
  logic [ERRCNT_W-1:0]       err_count;
  logic                      err_clr;

  modport master (
    output in_valid, sel, data, out_ready, err_clr,
    input  in_ready, out_valid, out_data, out_chan, sel_err, err_count
  );

  modport slave (
    input  in_valid, sel, data, out_ready, err_clr,
    output in_ready, out_valid, out_data, out_chan, sel_err, err_count
  );
endinterface

// File: rtl/onehot_mux_pipe.sv
// Pipelined one-hot select mux with one registered output stage and illegal-select counting.
// Define ONEHOT_MUX_PRIORITY_EN to accept multi-bit selects (lowest index wins); only zero is illegal.
//
// state | meaning
// EMPTY | output register holds no beat, out_valid=0
// FULL  | output register holds a beat,  out_valid=1
module onehot_mux_pipe #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int ERRCNT_W = 8
) (
  input logic              clk,
  input logic              rst,
  onehot_mux_pipe_if.slave bus
);
  localparam int CW = $clog2(CHANNELS);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t              state;
  logic [WIDTH-1:0]    data_q;
  logic [CW-1:0]       chan_q;
  logic                sel_err_q;
  logic [ERRCNT_W-1:0] err_count_q;

  logic [CHANNELS-1:0] sel_eff;
  logic                legal;
  logic                accept;
  logic                in_ready;
  logic [WIDTH-1:0]    mux_data;
  logic [CW-1:0]       mux_chan;

`ifdef ONEHOT_MUX_PRIORITY_EN
  // Isolate the lowest set bit so the AND-OR mux below still sees a one-hot vector.
  assign sel_eff = bus.sel & (~bus.sel + CHANNELS'(1));
  assign legal   = |bus.sel;
`else
  assign sel_eff = bus.sel;
  assign legal   = (|bus.sel) & ~(|(bus.sel & (bus.sel - CHANNELS'(1))));
`endif

  assign in_ready = (state == EMPTY) | bus.out_ready;
  assign accept   = bus.in_valid & in_ready;

  always_comb begin
    mux_data = '0;
    mux_chan = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      mux_data = mux_data | (bus.data[i*WIDTH +: WIDTH] & {WIDTH{sel_eff[i]}});
      mux_chan = mux_chan | (CW'(i) & {CW{sel_eff[i]}});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= EMPTY;
      data_q      <= '0;
      chan_q      <= '0;
      sel_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      sel_err_q <= accept & ~legal;

      if (accept && legal) begin
        data_q <= mux_data;
        chan_q <= mux_chan;
        state  <= FULL;
      end else if (bus.out_ready) begin
        state <= EMPTY;
      end

      // A clear coinciding with an illegal beat still records that beat.
      if (bus.err_clr) begin
        err_count_q <= (accept && !legal) ? ERRCNT_W'(1) : '0;
      end else if (accept && !legal && err_count_q != '1) begin
        err_count_q <= err_count_q + ERRCNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_chan  = chan_q;
  assign bus.sel_err   = sel_err_q;
  assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_onehot_mux_pipe.sv
// Directed bench for onehot_mux_pipe with a scoreboard queue of expected output beats.
// Honours ONEHOT_MUX_PRIORITY_EN when computing expected legality.
module tb_onehot_mux_pipe;
  localparam int CH = 4;
  localparam int W  = 8;
  localparam int EW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  onehot_mux_pipe_if #(.CHANNELS(CH), .WIDTH(W), .ERRCNT_W(EW)) bus ();
  onehot_mux_pipe #(.CHANNELS(CH), .WIDTH(W), .ERRCNT_W(EW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] c;
  } beat_t;

  beat_t        sb[$];
  int           tests = 0;
  int           fails = 0;
  logic         m_full = 1'b0;
  int           m_err  = 0;
  logic         m_sel_err = 1'b0;
  logic [31:0]  dflt = 32'h44332211;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_legal(input logic [3:0] s);
`ifdef ONEHOT_MUX_PRIORITY_EN
    return s != 4'b0;
`else
    return $countones(s) == 1;
`endif
  endfunction

  // One clock cycle: drive at negedge, check combinational/held outputs, then registered ones.
  task automatic cycle(input logic v, input logic [3:0] s, input logic [31:0] d,
                       input logic ordy, input logic clr);
    logic  exp_rdy, acc, leg;
    beat_t b;
    @(negedge clk);
    bus.in_valid  = v;
    bus.sel       = s;
    bus.data      = d;
    bus.out_ready = ordy;
    bus.err_clr   = clr;
    #1;
    exp_rdy = !m_full || ordy;
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(bus.out_valid), 32'(m_full));
    if (m_full) begin
      if (sb.size() == 0) begin
        chk("sb_nonempty", 32'(0), 32'(1));
      end else begin
        chk("out_data", 32'(bus.out_data), 32'(sb[0].d));
        chk("out_chan", 32'(bus.out_chan), 32'(sb[0].c));
        if (ordy) void'(sb.pop_front());
      end
    end
    acc = v && exp_rdy;
    leg = is_legal(s);
    if (acc && leg) begin
      b.c = 2'd0;
      for (int i = CH - 1; i >= 0; i--) if (s[i]) b.c = 2'(i);
      b.d = d[b.c*8 +: 8];
      sb.push_back(b);
      m_full = 1'b1;
    end else if (ordy) begin
      m_full = 1'b0;
    end
    m_sel_err = acc && !leg;
    if (clr) m_err = m_sel_err ? 1 : 0;
    else if (m_sel_err && m_err != 3) m_err++;
    @(posedge clk);
    #1;
    chk("sel_err", 32'(bus.sel_err), 32'(m_sel_err));
    chk("err_count", 32'(bus.err_count), 32'(m_err));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.sel       = '0;
    bus.data      = '0;
    bus.out_ready = 1'b0;
    bus.err_clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_out_data", 32'(bus.out_data), 32'(0));
    chk("rst_out_chan", 32'(bus.out_chan), 32'(0));
    chk("rst_sel_err", 32'(bus.sel_err), 32'(0));
    chk("rst_err_count", 32'(bus.err_count), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'(1));

    // Single beat: channel 2 -> 8'h33
    cycle(1'b1, 4'b0100, dflt, 1'b1, 1'b0);
    cycle(1'b0, 4'b0000, dflt, 1'b1, 1'b0);

    // Full-throughput stream across all channels
    cycle(1'b1, 4'b0001, dflt, 1'b1, 1'b0);
    cycle(1'b1, 4'b0010, dflt, 1'b1, 1'b0);
    cycle(1'b1, 4'b0100, dflt, 1'b1, 1'b0);
    cycle(1'b1, 4'b1000, dflt, 1'b1, 1'b0);
    cycle(1'b0, 4'b0000, dflt, 1'b1, 1'b0);

    // Backpressure: hold five cycles with a new beat waiting, then release
    cycle(1'b1, 4'b0001, 32'hA5B6C7D8, 1'b0, 1'b0);
    repeat (5) cycle(1'b1, 4'b1000, 32'h99887766, 1'b0, 1'b0);
    cycle(1'b1, 4'b1000, 32'h99887766, 1'b1, 1'b0);
    cycle(1'b0, 4'b0000, dflt, 1'b1, 1'b0);

    // Illegal selects, multi-bit select, saturation, clear with coincident illegal beat
    cycle(1'b1, 4'b0000, dflt, 1'b1, 1'b0);
    cycle(1'b1, 4'b0110, dflt, 1'b1, 1'b0);
    cycle(1'b0, 4'b0000, dflt, 1'b1, 1'b0);
    repeat (4) cycle(1'b1, 4'b0000, dflt, 1'b1, 1'b0);
    cycle(1'b1, 4'b0000, dflt, 1'b1, 1'b1);
    cycle(1'b0, 4'b0000, dflt, 1'b1, 1'b1);

    // Illegal beat arriving while the output drains
    cycle(1'b1, 4'b0010, 32'($urandom), 1'b1, 1'b0);
    cycle(1'b1, 4'b1010, 32'($urandom), 1'b1, 1'b0);
    cycle(1'b0, 4'b0000, dflt, 1'b1, 1'b0);

    // Asynchronous reset while FULL and stalled
    cycle(1'b1, 4'b0000, dflt, 1'b1, 1'b0);
    cycle(1'b1, 4'b0100, dflt, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("arst_err_count", 32'(bus.err_count), 32'(0));
    sb.delete();
    m_full = 1'b0;
    m_err  = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_in_ready", 32'(bus.in_ready), 32'(1));
    cycle(1'b1, 4'b0001, 32'h000000EE, 1'b1, 1'b0);
    cycle(1'b0, 4'b0000, dflt, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
